// File: rtl/bp_pkg.sv
// Shared branch-predictor types and saturating-counter helpers.
// The helpers work on a wide container so any counter width up to CTR_W_MAX can reuse them.
package bp_pkg;
  localparam int CTR_BITS_DEF = 2;
  localparam int CTR_W_MAX    = 16;

  typedef logic [CTR_BITS_DEF-1:0] ctr_t;
  typedef logic [CTR_W_MAX-1:0]    ctr_w_t;

  localparam ctr_t CTR_WEAK_NT = ctr_t'((1 << (CTR_BITS_DEF - 1)) - 1);
  localparam ctr_t CTR_MAX     = '1;

  function automatic ctr_w_t ctr_max_w(input int bits);
    return {CTR_W_MAX{1'b1}} >> (CTR_W_MAX - bits);
  endfunction

  function automatic ctr_w_t ctr_weak_w(input int bits);
    return ctr_max_w(bits) >> 1;
  endfunction

  function automatic ctr_w_t ctr_inc_sat(input ctr_w_t v, input int bits);
    return (v >= ctr_max_w(bits)) ? v : v + 1'b1;
  endfunction

  function automatic ctr_w_t ctr_dec_sat(input ctr_w_t v);
    return (v == '0) ? v : v - 1'b1;
  endfunction
endpackage

// File: rtl/sat_counter_table.sv
// Array of saturating counters: one combinational read port, one synchronous
// write (train) port, all entries loaded in a single reset cycle.
module sat_counter_table
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic [CTR_BITS-1:0]   rd_ctr,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic                  wr_taken
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] RST_VAL = CTR_BITS'(ctr_weak_w(CTR_BITS));

  logic [ENTRIES-1:0][CTR_BITS-1:0] r_ctr;
  logic [CTR_BITS-1:0]              w_cur;
  logic [CTR_BITS-1:0]              w_next;

  // Read is raw array contents: a same-cycle write is not bypassed.
  assign rd_ctr = r_ctr[rd_index];
  assign w_cur  = r_ctr[wr_index];
  assign w_next = wr_taken ? CTR_BITS'(ctr_inc_sat(ctr_w_t'(w_cur), CTR_BITS))
                           : CTR_BITS'(ctr_dec_sat(ctr_w_t'(w_cur)));

  always_ff @(posedge clk) begin
    if (reset)      r_ctr <= {ENTRIES{RST_VAL}};
    else if (wr_en) r_ctr[wr_index] <= w_next;
  end
endmodule

// File: rtl/gshare_predictor.sv
// Gshare predictor: PC word bits XOR non-speculative global history index a
// table of saturating counters; the resolved branch trains counter and history.
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int GHR_BITS   = 6,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PC_WIDTH-1:0]   pred_pc,
  output logic                  prediction,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  update_valid,
  input  logic [INDEX_BITS-1:0] update_index,
  input  logic                  update_taken
);
  logic [INDEX_BITS-1:0] w_ghr_ext;
  logic [CTR_BITS-1:0]   w_rd_ctr;

  generate
    if (GHR_BITS == 0) begin : g_no_ghr
      assign w_ghr_ext = '0;
    end else begin : g_ghr
      logic [GHR_BITS-1:0] r_ghr;
      if (GHR_BITS == 1) begin : g_one
        always_ff @(posedge clk) begin
          if (reset)             r_ghr <= '0;
          else if (update_valid) r_ghr <= update_taken;
        end
      end else begin : g_shift
        // Newest outcome enters at the LSB.
        always_ff @(posedge clk) begin
          if (reset)             r_ghr <= '0;
          else if (update_valid) r_ghr <= {r_ghr[GHR_BITS-2:0], update_taken};
        end
      end
      assign w_ghr_ext = INDEX_BITS'(r_ghr);
    end
  endgenerate

  assign pred_index = pred_pc[INDEX_BITS+1:2] ^ w_ghr_ext;
  assign prediction = w_rd_ctr[CTR_BITS-1];

  sat_counter_table #(
    .INDEX_BITS(INDEX_BITS),
    .CTR_BITS  (CTR_BITS)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .rd_index(pred_index),
    .rd_ctr  (w_rd_ctr),
    .wr_en   (update_valid),
    .wr_index(update_index),
    .wr_taken(update_taken)
  );
endmodule
